// File: rtl/kernel_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_pipe_ctrl
//
// Run controller for a fixed-latency kernel pipeline. A run is requested with
// a one-cycle start pulse; the controller then admits exactly nitems operand
// pairs, tracks them through the kernel with a LAT-deep valid-tag shift
// register, freezes the kernel whenever the result register is full and
// downstream is not ready, and pulses done once every result has been
// delivered.
//
// Parameters
//   NW   width of nitems and the item counters
//   LAT  kernel pipeline latency in cycles (1..16)
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   start        run request, sampled only in IDLE
//   nitems       items in the run, captured on an accepted start
//   in_valid     upstream operand pair valid
//   in_ready     controller/kernel accepts an operand pair this cycle
//   stall        freeze to the kernel's stall input
//   out_valid    kernel output register holds a valid result
//   out_ready    downstream accepts the result
//   busy         high in RUN and DRAIN
//   done         one-cycle pulse at the end of a run
//   items_out    results delivered in the current/last run
//   stall_cycles busy-and-stalled cycle counter, saturating
//                (only with KERNEL_PIPE_CTRL_PERFCNT_EN defined)
//   state_dbg    current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: an operand pair moves when in_valid && in_ready in the same
// cycle; a result moves when out_valid && out_ready in the same cycle.
// Neither side may make its valid depend combinationally on its ready.
//
// Optional feature macro: KERNEL_PIPE_CTRL_PERFCNT_EN
// -----------------------------------------------------------------------------
module kernel_pipe_ctrl #(
    parameter int NW  = 16,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] nitems,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          stall,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] items_out,
`ifdef KERNEL_PIPE_CTRL_PERFCNT_EN
    output logic [31:0]   stall_cycles,
`endif
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [NW-1:0] ONE = {{(NW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LAT-1:0]   vld_q, vld_d;
    logic [NW-1:0]    nitems_q, nitems_d;
    logic [NW-1:0]    issued_q, issued_d;
    logic [NW-1:0]    items_out_q, items_out_d;
    logic             accept;
    logic             transfer;

    // The output register is the last tag stage; the kernel only has to
    // freeze when that register is full and cannot be emptied this cycle.
    assign out_valid = vld_q[LAT-1];
    assign stall     = vld_q[LAT-1] & ~out_ready;
    assign in_ready  = (state_q == RUN) & ~stall & (issued_q < nitems_q);
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;
    assign busy      = (state_q == RUN) | (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign items_out = items_out_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        nitems_d    = nitems_q;
        issued_d    = issued_q;
        items_out_d = items_out_q;

        // Tags move in lock-step with the kernel; a bubble enters as 0.
        if (!stall) begin
            for (int i = LAT - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
            end
            vld_d[0] = accept;
        end

        if (accept) begin
            issued_d = issued_q + ONE;
        end
        if (transfer) begin
            items_out_d = items_out_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    nitems_d    = nitems;
                    issued_d    = '0;
                    items_out_d = '0;
                    state_d     = (nitems == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Uses the post-accept count so the last accept moves on
                // in the same cycle.
                if (issued_d == nitems_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (transfer && (items_out_d == nitems_q)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            nitems_q    <= '0;
            issued_q    <= '0;
            items_out_q <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            nitems_q    <= nitems_d;
            issued_q    <= issued_d;
            items_out_q <= items_out_d;
        end
    end

`ifdef KERNEL_PIPE_CTRL_PERFCNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((state_q == IDLE) && start) begin
            stall_cycles_d = '0;
        end else if (busy && stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_kernel_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kernel_pipe_ctrl
//
// Directed bench for kernel_pipe_ctrl. Two instances share clk/rst/start/
// nitems/in_valid: u_lat1 (LAT=1) and u_lat3 (LAT=3), each with its own
// out_ready. Every scenario begins from reset. Inputs are driven 1 ns after
// the rising edge and outputs are sampled 1 ns later; expected per-cycle
// waveforms are hand-derived, with cycle 0 being the cycle start is driven.
// -----------------------------------------------------------------------------
module tb_kernel_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] nitems;
  logic        in_valid;
  logic        or1, or3;

  logic        ir1, st1, ov1, bz1, dn1;
  logic [15:0] io1;
  logic [1:0]  sd1;
  logic        ir3, st3, ov3, bz3, dn3;
  logic [15:0] io3;
  logic [1:0]  sd3;
`ifdef KERNEL_PIPE_CTRL_PERFCNT_EN
  logic [31:0] sc1, sc3;
`endif

  int asserts = 0;
  int fails   = 0;

  kernel_pipe_ctrl #(.NW(16), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start), .nitems(nitems),
    .in_valid(in_valid), .in_ready(ir1), .stall(st1), .out_valid(ov1),
    .out_ready(or1), .busy(bz1), .done(dn1), .items_out(io1),
`ifdef KERNEL_PIPE_CTRL_PERFCNT_EN
    .stall_cycles(sc1),
`endif
    .state_dbg(sd1)
  );

  kernel_pipe_ctrl #(.NW(16), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start), .nitems(nitems),
    .in_valid(in_valid), .in_ready(ir3), .stall(st3), .out_valid(ov3),
    .out_ready(or3), .busy(bz3), .done(dn3), .items_out(io3),
`ifdef KERNEL_PIPE_CTRL_PERFCNT_EN
    .stall_cycles(sc3),
`endif
    .state_dbg(sd3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b0;
    start    = 1'b0;
    nitems   = 16'd0;
    in_valid = 1'b0;
    or1      = 1'b1;
    or3      = 1'b1;
    repeat (2) tick;
    rst = 1'b1;
    tick;
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b0; start = 1'b0; nitems = 16'd0; in_valid = 1'b0;
    or1 = 1'b0; or3 = 1'b0;
    #2;
    asserts++;
    if ({ir1, st1, ov1, bz1, dn1} !== 5'b0 || io1 !== 16'd0 || sd1 !== 2'd0) begin
      fails++;
      $display("FAIL reset_lat1: got ir/st/ov/bz/dn=%b%b%b%b%b items=%0d state=%0d, want 00000 0 0",
               ir1, st1, ov1, bz1, dn1, io1, sd1);
    end
    asserts++;
    if ({ir3, st3, ov3, bz3, dn3} !== 5'b0 || io3 !== 16'd0 || sd3 !== 2'd0) begin
      fails++;
      $display("FAIL reset_lat3: got ir/st/ov/bz/dn=%b%b%b%b%b items=%0d state=%0d, want 00000 0 0",
               ir3, st3, ov3, bz3, dn3, io3, sd3);
    end
  endtask

  // LAT=1, nitems=4, in_valid/out_ready high: in_ready 1..4, out_valid 2..5, done 6
  task automatic test_basic;
    do_reset;
    start = 1'b1; nitems = 16'd4; in_valid = 1'b1; or1 = 1'b1; or3 = 1'b1;
    #1;
    asserts++;
    if (ir1 !== 1'b0) begin
      fails++; $display("FAIL basic_idle_ready: got %b want 0", ir1);
    end
    for (int n = 1; n <= 8; n++) begin
      tick;
      start = 1'b0;
      #1;
      asserts++;
      if (ir1 !== (n >= 1 && n <= 4)) begin
        fails++; $display("FAIL basic_in_ready c%0d: got %b want %b", n, ir1, (n >= 1 && n <= 4));
      end
      asserts++;
      if (ov1 !== (n >= 2 && n <= 5)) begin
        fails++; $display("FAIL basic_out_valid c%0d: got %b want %b", n, ov1, (n >= 2 && n <= 5));
      end
      asserts++;
      if (dn1 !== (n == 6)) begin
        fails++; $display("FAIL basic_done c%0d: got %b want %b", n, dn1, (n == 6));
      end
      asserts++;
      if (bz1 !== (n >= 1 && n <= 5)) begin
        fails++; $display("FAIL basic_busy c%0d: got %b want %b", n, bz1, (n >= 1 && n <= 5));
      end
    end
    // items_out holds its final value in IDLE
    asserts++;
    if (io1 !== 16'd4 || sd1 !== 2'd0) begin
      fails++; $display("FAIL basic_items_out: got %0d state %0d want 4 state 0", io1, sd1);
    end
  endtask

  // LAT=3, nitems=5, out_ready low in cycles 4..6
  task automatic test_stall;
    int xfers;
    xfers = 0;
    do_reset;
    start = 1'b1; nitems = 16'd5; in_valid = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      if (n > 1) tick;
      or3 = !(n >= 4 && n <= 6);
      #1;
      if (ov3 && or3) xfers++;
      asserts++;
      if (st3 !== (n >= 4 && n <= 6)) begin
        fails++; $display("FAIL stall_stall c%0d: got %b want %b", n, st3, (n >= 4 && n <= 6));
      end
      asserts++;
      if (ir3 !== ((n >= 1 && n <= 3) || n == 7 || n == 8)) begin
        fails++; $display("FAIL stall_in_ready c%0d: got %b want %b", n, ir3,
                          ((n >= 1 && n <= 3) || n == 7 || n == 8));
      end
      asserts++;
      if (ov3 !== (n >= 4 && n <= 11)) begin
        fails++; $display("FAIL stall_out_valid c%0d: got %b want %b", n, ov3, (n >= 4 && n <= 11));
      end
      asserts++;
      if (dn3 !== (n == 12)) begin
        fails++; $display("FAIL stall_done c%0d: got %b want %b", n, dn3, (n == 12));
      end
    end
    asserts++;
    if (io3 !== 16'd5 || xfers != 5) begin
      fails++; $display("FAIL stall_count: got items_out=%0d transfers=%0d want 5 5", io3, xfers);
    end
  endtask

  // nitems=0: done in cycle 1, in_ready never high, items_out 0
  task automatic test_zero;
    do_reset;
    start = 1'b1; nitems = 16'd0; in_valid = 1'b1;
    for (int n = 0; n <= 3; n++) begin
      if (n > 0) begin
        tick;
        start = 1'b0;
      end
      #1;
      asserts++;
      if (ir1 !== 1'b0) begin
        fails++; $display("FAIL zero_in_ready c%0d: got %b want 0", n, ir1);
      end
      asserts++;
      if (dn1 !== (n == 1)) begin
        fails++; $display("FAIL zero_done c%0d: got %b want %b", n, dn1, (n == 1));
      end
    end
    asserts++;
    if (io1 !== 16'd0 || bz1 !== 1'b0) begin
      fails++; $display("FAIL zero_items_out: got %0d busy %b want 0 0", io1, bz1);
    end
  endtask

  // start with nitems=9 in cycle 2 of a 3-item run is ignored
  task automatic test_start_ignored;
    do_reset;
    start = 1'b1; nitems = 16'd3; in_valid = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick;
      start  = (n == 2);
      nitems = (n >= 2) ? 16'd9 : 16'd3;
      #1;
      asserts++;
      if (ir1 !== (n >= 1 && n <= 3)) begin
        fails++; $display("FAIL ignore_in_ready c%0d: got %b want %b", n, ir1, (n >= 1 && n <= 3));
      end
      asserts++;
      if (dn1 !== (n == 5)) begin
        fails++; $display("FAIL ignore_done c%0d: got %b want %b", n, dn1, (n == 5));
      end
    end
    asserts++;
    if (io1 !== 16'd3 || sd1 !== 2'd0) begin
      fails++; $display("FAIL ignore_items_out: got %0d state %0d want 3 0", io1, sd1);
    end
  endtask

  // reset mid-run after 2 of 6 accepts, then a clean 2-item run
  task automatic test_reset_abort;
    do_reset;
    start = 1'b1; nitems = 16'd6; in_valid = 1'b1;
    tick; start = 1'b0;       // cycle 1: accept #1
    tick;                     // cycle 2: accept #2, transfer #1
    tick;                     // cycle 3
    #1;
    asserts++;
    if (io1 !== 16'd1 || bz1 !== 1'b1) begin
      fails++; $display("FAIL abort_pre: got items_out=%0d busy=%b want 1 1", io1, bz1);
    end
    rst = 1'b0;
    #1;
    asserts++;
    if ({ir1, st1, ov1, bz1, dn1} !== 5'b0 || io1 !== 16'd0 || sd1 !== 2'd0) begin
      fails++; $display("FAIL abort_async: got ir/st/ov/bz/dn=%b%b%b%b%b items=%0d state=%0d, want 00000 0 0",
                        ir1, st1, ov1, bz1, dn1, io1, sd1);
    end
    for (int n = 0; n < 4; n++) begin
      tick;
      if (n == 1) rst = 1'b1;
      #1;
      asserts++;
      if (dn1 !== 1'b0 || bz1 !== 1'b0) begin
        fails++; $display("FAIL abort_idle c%0d: got done=%b busy=%b want 0 0", n, dn1, bz1);
      end
    end
    start = 1'b1; nitems = 16'd2;
    for (int n = 1; n <= 5; n++) begin
      tick;
      start = 1'b0;
      #1;
      asserts++;
      if (ir1 !== (n <= 2) || ov1 !== (n >= 2 && n <= 3) || dn1 !== (n == 4)) begin
        fails++; $display("FAIL abort_rerun c%0d: got ir/ov/dn=%b%b%b want %b%b%b", n, ir1, ov1, dn1,
                          (n <= 2), (n >= 2 && n <= 3), (n == 4));
      end
    end
    asserts++;
    if (io1 !== 16'd2) begin
      fails++; $display("FAIL abort_items_out: got %0d want 2", io1);
    end
  endtask

`ifdef KERNEL_PIPE_CTRL_PERFCNT_EN
  // LAT=1, nitems=1, out_ready low cycles 2..8 while the result waits
  task automatic test_perfcnt;
    do_reset;
    start = 1'b1; nitems = 16'd1; in_valid = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick;
      start = 1'b0;
      or1 = !(n >= 2 && n <= 8);
      #1;
      if (n == 1) begin
        asserts++;
        if (sc1 !== 32'd0) begin
          fails++; $display("FAIL perf_clear: got %0d want 0", sc1);
        end
      end
      if (n == 10) begin
        asserts++;
        if (dn1 !== 1'b1) begin
          fails++; $display("FAIL perf_done: got %b want 1", dn1);
        end
      end
    end
    asserts++;
    if (sc1 !== 32'd7) begin
      fails++; $display("FAIL perf_stall_cycles: got %0d want 7", sc1);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero;
    test_start_ignored;
    test_reset_abort;
`ifdef KERNEL_PIPE_CTRL_PERFCNT_EN
    test_perfcnt;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/kernel_pipe_ctrl.md
KERNEL_PIPE_CTRL -- requirements
Module: kernel_pipe_ctrl

Interface
REQ-001 SHALL have parameter NW, default 16, width of the item counters and of nitems.
REQ-002 SHALL have parameter LAT, default 1, controlled kernel pipeline latency in cycles (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 SHALL have port nitems  input  NW  number of work items in the run; captured on accepted start.
REQ-007 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-008 SHALL have port in_ready  output  1  controller/kernel accepts an operand pair this cycle.
REQ-009 SHALL have port stall  output  1  freeze signal driven to the kernel's stall input.
REQ-010 SHALL have port out_valid  output  1  kernel output register holds a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-014 SHALL have port items_out  output  NW  results delivered in the current/last run.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-016 IDLE -> RUN on start, capturing nitems and clearing issued/items_out; if nitems==0, IDLE -> DONE instead.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 SHALL hold a LAT-bit valid-tag shift register vld; vld advances by one stage each cycle stall==0 and holds when stall==1.
REQ-019 stall SHALL equal vld[LAT-1] AND NOT out_ready (combinational).
REQ-020 in_ready SHALL equal (state==RUN) AND NOT stall AND (issued < nitems).
REQ-021 Accept = in_valid AND in_ready; vld[0] loads Accept when stall==0; issued increments on Accept.
REQ-022 out_valid SHALL equal vld[LAT-1]; transfer = out_valid AND out_ready; items_out increments on transfer.
REQ-023 Unstalled latency SHALL be exactly LAT cycles from accept edge to out_valid high.
REQ-024 RUN -> DRAIN when issued reaches nitems (including same-cycle last accept).
REQ-025 DRAIN -> DONE on the transfer that makes items_out equal nitems; done asserts in that DONE cycle.
REQ-026 Bubbles (in_valid low) SHALL insert 0 into vld; no item loss or duplication under any in_valid/out_ready pattern.
REQ-027 Counters SHALL never wrap within a run; nitems = 2^NW-1 is legal.
REQ-028 items_out SHALL retain its final value in IDLE until next accepted start.

Reset
REQ-029 On rst low: state=IDLE, vld=0, issued=0, items_out=0, in_ready=0, stall=0, out_valid=0, busy=0, done=0.
REQ-030 Reset asserted mid-run SHALL abort immediately; no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-031 Macro KERNEL_PIPE_CTRL_PERFCNT_EN defined: SHALL add output stall_cycles (32 bits), cleared on accepted start and reset, incrementing each cycle busy AND stall, saturating at 0xFFFFFFFF.
REQ-032 Macro undefined: stall_cycles port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 LAT=1, nitems=4, in_valid and out_ready held high -> in_ready 4 cycles, out_valid cycles 2..5 after start, done one cycle later, items_out=4.
REQ-034 LAT=3, nitems=5, out_ready low cycles 4-6 -> stall high exactly while vld[2]&!out_ready, in_ready low then, items_out=5, no duplicate.
REQ-035 nitems=0 start -> done pulse next cycle, in_ready never high, items_out=0.
REQ-036 Start asserted during RUN with nitems=9 -> ignored; run completes with original nitems=3.
REQ-037 rst low after 2 of 6 items accepted -> all outputs zero asynchronously, no done; new start with nitems=2 completes normally.
REQ-038 With KERNEL_PIPE_CTRL_PERFCNT_EN, out_ready low 7 busy cycles while out_valid -> stall_cycles=7.
